// File: rtl/fir_xifu_issue_buffer.sv
// ---------------------------------------------------------------------------
// fir_xifu_issue_buffer
//
// Elastic issue buffer between the core's XIF issue channel and the FIR
// coprocessor decode stage. Holds up to DEPTH offloaded instructions with
// their source operands. Commit/kill messages are tracked per entry: killed
// entries are drained at the head without being presented downstream, and
// committed entries are flagged on out_commit_o.
//
// Optional feature macro: FIR_XIFU_ISSUE_BYPASS_EN
//   When defined, an instruction offered to an empty buffer is forwarded
//   combinationally to the outputs (zero latency). If it is accepted
//   downstream in that cycle it is never stored.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   clear_i                synchronous flush of all entries
//   issue_valid_i/_ready_o issue handshake (ready is registered)
//   issue_instr_i/_id_i/_rs_i  instruction word, id, {rs2, rs1}
//   commit_valid_i/_id_i/_kill_i  commit (kill=0) or kill (kill=1) message
//   out_valid_o/_ready_i   decode-side handshake
//   out_instr_o/_id_o/_rs_o/_commit_o  head entry contents
//   count_o                occupancy, including killed entries not drained
// ---------------------------------------------------------------------------
module fir_xifu_issue_buffer #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int RF_W  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [31:0]                issue_instr_i,
    input  logic [ID_W-1:0]            issue_id_i,
    input  logic [2*RF_W-1:0]          issue_rs_i,
    input  logic                       commit_valid_i,
    input  logic [ID_W-1:0]            commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_instr_o,
    output logic [ID_W-1:0]            out_id_o,
    output logic [2*RF_W-1:0]          out_rs_o,
    output logic                       out_commit_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    // Entry storage (data, no reset) and per-entry status flags
    logic [31:0]       instr_mem [DEPTH];
    logic [ID_W-1:0]   id_mem    [DEPTH];
    logic [2*RF_W-1:0] rs_mem    [DEPTH];
    logic [DEPTH-1:0]  killed_q;
    logic [DEPTH-1:0]  committed_q;

    // Control state
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ready_q;

    logic flush;
    logic push;
    logic store;
    logic pop_mem;
    logic drain;
    logic head_live;
    logic head_killed;
    logic in_match;
    logic byp;
    logic byp_take;

    assign flush       = clear_i | rst_i;
    assign head_killed = killed_q[rd_ptr];
    assign head_live   = (count_q != '0) && !head_killed;
    assign drain       = (count_q != '0) && head_killed;

    // A commit message naming the id being issued this cycle also applies
    // to that instruction.
    assign in_match    = commit_valid_i && (commit_id_i == issue_id_i);

    assign push        = issue_valid_i && ready_q;

`ifdef FIR_XIFU_ISSUE_BYPASS_EN
    assign byp = (count_q == '0) && issue_valid_i && ready_q;
`else
    assign byp = 1'b0;
`endif

    // Head (or bypassed issue) presented combinationally to decode
    always_comb begin
        out_valid_o  = head_live;
        out_instr_o  = instr_mem[rd_ptr];
        out_id_o     = id_mem[rd_ptr];
        out_rs_o     = rs_mem[rd_ptr];
        out_commit_o = head_live && committed_q[rd_ptr];
        if (byp) begin
            out_valid_o  = !(in_match && commit_kill_i);
            out_instr_o  = issue_instr_i;
            out_id_o     = issue_id_i;
            out_rs_o     = issue_rs_i;
            out_commit_o = in_match && !commit_kill_i;
        end
    end

    // A bypassed instruction accepted downstream is consumed without storage;
    // otherwise every accepted push lands in the FIFO.
    assign byp_take = byp && out_valid_o && out_ready_i;
    assign store    = push && !byp_take;
    assign pop_mem  = !byp && head_live && out_ready_i;

    always_comb begin
        count_d = count_q + CW'(store) - CW'(pop_mem | drain);
        if (flush) begin
            count_d = '0;
        end
    end

    // Control registers
    always_ff @(posedge clk_i) begin
        if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_mem || drain) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_d;
        end
        // Ready is derived from next occupancy only, so it never depends
        // combinationally on out_ready_i; a full buffer refuses a push even
        // while popping.
        if (rst_i) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (count_d < CW'(DEPTH));
        end
    end

    // Status flags: commit/kill marks all matching entries; a fresh push
    // overrides the slot it writes with its own (possibly same-cycle) flags.
    // Flags of unoccupied slots are meaningless, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (!flush) begin
            if (commit_valid_i) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (id_mem[i] == commit_id_i) begin
                        if (commit_kill_i) begin
                            killed_q[i] <= 1'b1;
                        end else begin
                            committed_q[i] <= 1'b1;
                        end
                    end
                end
            end
            if (store) begin
                killed_q[wr_ptr]    <= in_match && commit_kill_i;
                committed_q[wr_ptr] <= in_match && !commit_kill_i;
            end
        end
    end

    // Entry data
    always_ff @(posedge clk_i) begin
        if (store) begin
            instr_mem[wr_ptr] <= issue_instr_i;
            id_mem[wr_ptr]    <= issue_id_i;
            rs_mem[wr_ptr]    <= issue_rs_i;
        end
    end

    assign issue_ready_o = ready_q;
    assign count_o       = count_q;

endmodule

// File: tb/tb_fir_xifu_issue_buffer.sv
module tb_fir_xifu_issue_buffer;

    localparam int DEPTH = 4;
    localparam int ID_W  = 4;
    localparam int RF_W  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              clear_i = 1'b0;
    logic              issue_valid_i = 1'b0;
    logic              issue_ready_o;
    logic [31:0]       issue_instr_i = '0;
    logic [ID_W-1:0]   issue_id_i = '0;
    logic [2*RF_W-1:0] issue_rs_i = '0;
    logic              commit_valid_i = 1'b0;
    logic [ID_W-1:0]   commit_id_i = '0;
    logic              commit_kill_i = 1'b0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [31:0]       out_instr_o;
    logic [ID_W-1:0]   out_id_o;
    logic [2*RF_W-1:0] out_rs_o;
    logic              out_commit_o;
    logic [CW-1:0]     count_o;

    int checks = 0;
    int errors = 0;

    fir_xifu_issue_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .RF_W(RF_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i), .issue_rs_i(issue_rs_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_instr_o(out_instr_o), .out_id_o(out_id_o), .out_rs_o(out_rs_o),
        .out_commit_o(out_commit_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [ID_W-1:0] id);
        issue_valid_i = v;
        issue_id_i    = id;
        issue_instr_i = 32'h0000_0100 + 32'(id);
        issue_rs_i    = {32'hA000_0000 + 32'(id), 32'h5000_0000 + 32'(id)};
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step(); step();
        checks++; if (issue_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", issue_ready_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid_o); end
        checks++; if (out_commit_o !== 1'b0) begin errors++; $display("FAIL reset_commit: got %b want 0", out_commit_o); end
        rst_i = 1'b0;
        step();
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", issue_ready_o); end
    endtask

    task automatic test_fill_drain();
        out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(1'b1, ID_W'(i));
            step();
            checks++; if (count_o !== 3'(i + 1)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", i, count_o, i + 1); end
            checks++; if (issue_ready_o !== (i < 3)) begin errors++; $display("FAIL fill_ready%0d: got %b want %b", i, issue_ready_o, (i < 3)); end
        end
        set_issue(1'b0, '0);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_valid_o !== 1'b1 || out_id_o !== ID_W'(i)) begin errors++; $display("FAIL pop_order%0d: got v=%b id=%0d want v=1 id=%0d", i, out_valid_o, out_id_o, i); end
            checks++; if (out_instr_o !== 32'h100 + 32'(i) || out_rs_o !== {32'hA000_0000 + 32'(i), 32'h5000_0000 + 32'(i)}) begin errors++; $display("FAIL pop_data%0d: got instr=%h rs=%h", i, out_instr_o, out_rs_o); end
            step();
            if (i == 0) begin
                checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL ready_return: got %b want 1", issue_ready_o); end
            end
        end
        checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL drained: got count=%0d v=%b want 0 0", count_o, out_valid_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_kill_drain();
        out_ready_i = 1'b0;
        for (int i = 5; i < 8; i++) begin
            set_issue(1'b1, ID_W'(i));
            step();
        end
        set_issue(1'b0, '0);
        commit_valid_i = 1'b1; commit_id_i = 4'd5; commit_kill_i = 1'b1;
        step();
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        out_ready_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL kill_drain_valid: got %b want 0", out_valid_o); end
        step();
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL kill_drain_count: got %0d want 2", count_o); end
        checks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd6) begin errors++; $display("FAIL kill_first_out: got v=%b id=%0d want v=1 id=6", out_valid_o, out_id_o); end
        step();
        checks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd7) begin errors++; $display("FAIL kill_second_out: got v=%b id=%0d want v=1 id=7", out_valid_o, out_id_o); end
        step();
        checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL kill_empty: got count=%0d v=%b want 0 0", count_o, out_valid_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_same_cycle_commit();
        out_ready_i = 1'b0;
        set_issue(1'b1, 4'd2);
        commit_valid_i = 1'b1; commit_id_i = 4'd2; commit_kill_i = 1'b0;
        step();
        set_issue(1'b1, 4'd3);
        commit_id_i = 4'd3; commit_kill_i = 1'b1;
        step();
        set_issue(1'b0, '0);
        commit_valid_i = 1'b0; commit_kill_i = 1'b0;
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL sc_count: got %0d want 2", count_o); end
        out_ready_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd2 || out_commit_o !== 1'b1) begin errors++; $display("FAIL sc_commit: got v=%b id=%0d c=%b want 1 2 1", out_valid_o, out_id_o, out_commit_o); end
        step();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL sc_kill_hidden: got v=%b id=%0d want v=0", out_valid_o, out_id_o); end
        step();
        checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL sc_empty: got count=%0d v=%b want 0 0", count_o, out_valid_o); end
        out_ready_i = 1'b0;
    endtask

    task automatic test_clear();
        out_ready_i = 1'b0;
        for (int i = 9; i < 12; i++) begin
            set_issue(1'b1, ID_W'(i));
            step();
        end
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL clr_pre_count: got %0d want 3", count_o); end
        clear_i = 1'b1;
        set_issue(1'b1, 4'd12);
        step();
        clear_i = 1'b0;
        set_issue(1'b0, '0);
        checks++; if (count_o !== 3'd0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL clr_state: got count=%0d v=%b want 0 0", count_o, out_valid_o); end
        checks++; if (dut.wr_ptr !== 2'd0 || dut.rd_ptr !== 2'd0) begin errors++; $display("FAIL clr_ptrs: got wr=%0d rd=%0d want 0 0", dut.wr_ptr, dut.rd_ptr); end
        checks++; if (issue_ready_o !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b want 1", issue_ready_o); end
        set_issue(1'b1, 4'd13);
        step();
        set_issue(1'b0, '0);
        checks++; if (dut.wr_ptr !== 2'd1 || out_valid_o !== 1'b1 || out_id_o !== 4'd13) begin errors++; $display("FAIL clr_repush: got wr=%0d v=%b id=%0d want 1 1 13", dut.wr_ptr, out_valid_o, out_id_o); end
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL clr_final: got %0d want 0", count_o); end
    endtask

    task automatic test_random_reset();
        logic [31:0] qi[$];
        logic [63:0] qr[$];
        logic [31:0] seq;
        logic push_hs, pop_hs;
        seq = 32'h1000;
        for (int c = 0; c < 200; c++) begin
            issue_valid_i = ($urandom_range(0, 3) != 0);
            out_ready_i   = ($urandom_range(0, 2) != 0);
            issue_instr_i = seq;
            issue_id_i    = seq[ID_W-1:0];
            issue_rs_i    = {$urandom, $urandom};
            #1;
            checks++; if (count_o !== 3'(qi.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count_o, qi.size()); end
            checks++; if (out_valid_o !== (qi.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid_o, (qi.size() != 0)); end
            if (out_valid_o && qi.size() != 0) begin
                checks++; if (out_instr_o !== qi[0] || out_rs_o !== qr[0]) begin errors++; $display("FAIL rnd_order c%0d: got %h/%h want %h/%h", c, out_instr_o, out_rs_o, qi[0], qr[0]); end
            end
            push_hs = issue_valid_i && issue_ready_o;
            pop_hs  = out_valid_o && out_ready_i;
            @(posedge clk);
            if (pop_hs && qi.size() != 0) begin void'(qi.pop_front()); void'(qr.pop_front()); end
            if (push_hs) begin qi.push_back(issue_instr_i); qr.push_back(issue_rs_i); seq = seq + 1; end
            #1;
            checks++; if (issue_ready_o !== (qi.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, issue_ready_o, (qi.size() < DEPTH)); end
        end
        checks++; if (seq < 32'h1000 + 32'd20) begin errors++; $display("FAIL rnd_progress: got %0d pushes want >=20", seq - 32'h1000); end
        rst_i = 1'b1;
        issue_valid_i = 1'b1;
        step();
        checks++; if (issue_ready_o !== 1'b0 || count_o !== 3'd0 || out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset: got rdy=%b count=%0d v=%b want 0 0 0", issue_ready_o, count_o, out_valid_o); end
        step();
        checks++; if (issue_ready_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL mid_reset_hold: got rdy=%b count=%0d want 0 0", issue_ready_o, count_o); end
        rst_i = 1'b0;
        issue_valid_i = 1'b0;
        out_ready_i = 1'b0;
        step();
        checks++; if (issue_ready_o !== 1'b1 || count_o !== 3'd0) begin errors++; $display("FAIL post_reset: got rdy=%b count=%0d want 1 0", issue_ready_o, count_o); end
    endtask

`ifdef FIR_XIFU_ISSUE_BYPASS_EN
    task automatic test_bypass();
        set_issue(1'b1, 4'd4);
        out_ready_i = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b1 || out_id_o !== 4'd4) begin errors++; $display("FAIL byp_same_cycle: got v=%b id=%0d want 1 4", out_valid_o, out_id_o); end
        step();
        set_issue(1'b0, '0);
        out_ready_i = 1'b0;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL byp_count: got %0d want 0", count_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_drain();
        test_kill_drain();
        test_same_cycle_commit();
        test_clear();
`ifdef FIR_XIFU_ISSUE_BYPASS_EN
        test_bypass();
`endif
        test_random_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
